// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the memory-stage access unit.
// Load/store type codes match the decode stage; state codes name the bus FSM.
package mem_access_unit_pkg;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  localparam logic [2:0] LOAD_DEF = 3'd0;
  localparam logic [2:0] LOAD_LB  = 3'd1;
  localparam logic [2:0] LOAD_LH  = 3'd2;
  localparam logic [2:0] LOAD_LW  = 3'd3;
  localparam logic [2:0] LOAD_LBU = 3'd4;
  localparam logic [2:0] LOAD_LHU = 3'd5;

  localparam logic [1:0] STORE_DEF = 2'd0;
  localparam logic [1:0] STORE_SB  = 2'd1;
  localparam logic [1:0] STORE_SH  = 2'd2;
  localparam logic [1:0] STORE_SW  = 2'd3;

  // Unrecognised type codes fall back to word width, the strictest alignment.
  function automatic logic misaligned_access(input logic is_load, input logic [2:0] lt,
                                             input logic [1:0] st, input logic [1:0] a);
    logic res;
    if (is_load) begin
      case (lt)
        LOAD_LB, LOAD_LBU: res = 1'b0;
        LOAD_LH, LOAD_LHU: res = a[0];
        default:           res = (a != 2'b00);
      endcase
    end else begin
      case (st)
        STORE_SB: res = 1'b0;
        STORE_SH: res = a[0];
        default:  res = (a != 2'b00);
      endcase
    end
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] a);
    logic [3:0] be;
    case (st)
      STORE_SB: be = 4'b0001 << a;
      STORE_SH: be = a[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] d);
    logic [31:0] w;
    case (st)
      STORE_SB: w = {4{d[7:0]}};
      STORE_SH: w = {2{d[15:0]}};
      default:  w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-port data-memory bus with a req/ready handshake.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero extends it.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select and extension by load type.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LOAD_LB:  data = {{24{byte_lane[7]}}, byte_lane};
      LOAD_LBU: data = {24'd0, byte_lane};
      LOAD_LH:  data = {{16{half_lane[15]}}, half_lane};
      LOAD_LHU: data = {16'd0, half_lane};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: drives the data bus, stalls while an access is outstanding,
// and produces the MEM/WB register.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [31:0]               in_addr,
  input  logic [31:0]               in_store_data,
  input  logic                      in_mem_write,
  input  logic                      in_wb_load,
  input  logic [2:0]                in_load_type,
  input  logic [1:0]                in_store_type,
  input  logic [4:0]                in_rd,
  input  logic                      in_wb_reg_file,
  mem_access_unit_if.master         dmem,
  output logic                      mem_stall,
  output logic                      wb_valid,
  output logic [31:0]               wb_data,
  output logic [4:0]                wb_rd,
  output logic                      wb_reg_write,
  output logic                      wb_misalign
);

  mem_state_e  state, state_next;
  logic        is_mem_op, misaligned;
  logic [1:0]  addr_lo_r, addr_lo_next;
  logic [2:0]  load_type_r, load_type_next;
  logic        is_store_r, is_store_next;
  logic        reg_file_r, reg_file_next;
  logic [4:0]  rd_r, rd_next;
  logic        req_next, we_next;
  logic [31:0] addr_next, wdata_next;
  logic [3:0]  be_next;
  logic        wb_valid_next, wb_reg_write_next, wb_misalign_next;
  logic [31:0] wb_data_next, load_data;
  logic [4:0]  wb_rd_next;

  assign is_mem_op  = in_valid & (in_wb_load | (in_mem_write & (in_store_type != STORE_DEF)));
  assign misaligned = misaligned_access(in_wb_load, in_load_type, in_store_type, in_addr[1:0]);

  load_align u_load_align (
    .rdata     (dmem.dmem_rdata),
    .addr_lo   (addr_lo_r),
    .load_type (load_type_r),
    .data      (load_data)
  );

  // Next-state and next-register values; request fields hold unless changed.
  always_comb begin
    state_next        = state;
    mem_stall         = 1'b0;
    req_next          = dmem.dmem_req;
    we_next           = dmem.dmem_we;
    addr_next         = dmem.dmem_addr;
    be_next           = dmem.dmem_be;
    wdata_next        = dmem.dmem_wdata;
    addr_lo_next      = addr_lo_r;
    load_type_next    = load_type_r;
    is_store_next     = is_store_r;
    reg_file_next     = reg_file_r;
    rd_next           = rd_r;
    wb_valid_next     = 1'b0;
    wb_data_next      = wb_data;
    wb_rd_next        = wb_rd;
    wb_reg_write_next = 1'b0;
    wb_misalign_next  = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (in_valid && !is_mem_op) begin
          wb_valid_next     = 1'b1;
          wb_data_next      = in_addr;
          wb_rd_next        = in_rd;
          wb_reg_write_next = in_wb_reg_file;
        end else if (is_mem_op && misaligned) begin
          wb_valid_next    = 1'b1;
          wb_misalign_next = 1'b1;
          wb_data_next     = 32'd0;
          wb_rd_next       = in_rd;
        end else if (is_mem_op) begin
          mem_stall      = 1'b1;
          state_next     = MEM_BUSY;
          req_next       = 1'b1;
          we_next        = ~in_wb_load;
          addr_next      = {in_addr[31:2], 2'b00};
          be_next        = in_wb_load ? 4'b1111 : store_be(in_store_type, in_addr[1:0]);
          wdata_next     = in_wb_load ? 32'd0 : store_wdata(in_store_type, in_store_data);
          addr_lo_next   = in_addr[1:0];
          load_type_next = in_load_type;
          is_store_next  = ~in_wb_load;
          reg_file_next  = in_wb_reg_file;
          rd_next        = in_rd;
        end else begin
          state_next = MEM_IDLE;
        end
      end
      MEM_BUSY: begin
        mem_stall = ~dmem.dmem_ready;
        if (dmem.dmem_ready) begin
          state_next        = MEM_IDLE;
          req_next          = 1'b0;
          we_next           = 1'b0;
          be_next           = 4'b0000;
          wb_valid_next     = 1'b1;
          wb_data_next      = is_store_r ? 32'd0 : load_data;
          wb_rd_next        = rd_r;
          wb_reg_write_next = ~is_store_r & reg_file_r;
        end else begin
          state_next = MEM_BUSY;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  // State, bus request and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= MEM_IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_be    <= 4'b0000;
      dmem.dmem_wdata <= 32'd0;
      addr_lo_r       <= 2'd0;
      load_type_r     <= LOAD_DEF;
      is_store_r      <= 1'b0;
      reg_file_r      <= 1'b0;
      rd_r            <= 5'd0;
      wb_valid        <= 1'b0;
      wb_data         <= 32'd0;
      wb_rd           <= 5'd0;
      wb_reg_write    <= 1'b0;
      wb_misalign     <= 1'b0;
    end else begin
      state           <= state_next;
      dmem.dmem_req   <= req_next;
      dmem.dmem_we    <= we_next;
      dmem.dmem_addr  <= addr_next;
      dmem.dmem_be    <= be_next;
      dmem.dmem_wdata <= wdata_next;
      addr_lo_r       <= addr_lo_next;
      load_type_r     <= load_type_next;
      is_store_r      <= is_store_next;
      reg_file_r      <= reg_file_next;
      rd_r            <= rd_next;
      wb_valid        <= wb_valid_next;
      wb_data         <= wb_data_next;
      wb_rd           <= wb_rd_next;
      wb_reg_write    <= wb_reg_write_next;
      wb_misalign     <= wb_misalign_next;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus multi-cycle sequences.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_mem_write, in_wb_load, in_wb_reg_file;
  logic [31:0] in_addr, in_store_data;
  logic [2:0]  in_load_type;
  logic [1:0]  in_store_type;
  logic [4:0]  in_rd;
  logic        mem_stall, wb_valid, wb_reg_write, wb_misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  int          errors = 0;
  int          checks = 0;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_mem_write(in_mem_write), .in_wb_load(in_wb_load),
    .in_load_type(in_load_type), .in_store_type(in_store_type), .in_rd(in_rd),
    .in_wb_reg_file(in_wb_reg_file), .dmem(bus), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mem_write;
    logic        wb_load;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        reg_file;
    logic [4:0]  rd;
    logic        exp_mem;
    logic        exp_we;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb_data;
    logic        exp_rw;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic mw, input logic ld, input logic [2:0] lt, input logic [1:0] st,
                          input logic [31:0] a, input logic [31:0] d, input logic rf, input logic [4:0] rd);
    in_valid = 1'b1; in_mem_write = mw; in_wb_load = ld; in_load_type = lt;
    in_store_type = st; in_addr = a; in_store_data = d; in_wb_reg_file = rf; in_rd = rd;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_mem_write = 1'b0; in_wb_load = 1'b0; in_load_type = LOAD_DEF;
    in_store_type = STORE_DEF; in_addr = 32'd0; in_store_data = 32'd0;
    in_wb_reg_file = 1'b0; in_rd = 5'd0;
  endtask

  initial begin
    // mw ld lt st addr sdata rdata rf rd | mem we daddr be wdata wb_data rw mis
    vecs[0]  = '{1'b0, 1'b0, LOAD_DEF, STORE_DEF, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 5'd5,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0000_1234, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, LOAD_DEF, STORE_SB, 32'h0000_0103, 32'h0000_00AB, 32'h0, 1'b0, 5'd0,
                 1'b1, 1'b1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, LOAD_LB, STORE_DEF, 32'h0000_0101, 32'h0, 32'h0000_8000, 1'b1, 5'd7,
                 1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, LOAD_LBU, STORE_DEF, 32'h0000_0101, 32'h0, 32'h0000_8000, 1'b1, 5'd8,
                 1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'h0000_0080, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, LOAD_DEF, STORE_SH, 32'h0000_0206, 32'h1234_BEEF, 32'h0, 1'b0, 5'd0,
                 1'b1, 1'b1, 32'h0000_0204, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, LOAD_DEF, STORE_SW, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0,
                 1'b1, 1'b1, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, LOAD_LW, STORE_DEF, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1'b1, 5'd9,
                 1'b1, 1'b0, 32'h0000_0400, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, LOAD_LHU, STORE_DEF, 32'h0000_0502, 32'h0, 32'h8001_0000, 1'b1, 5'd10,
                 1'b1, 1'b0, 32'h0000_0500, 4'b1111, 32'h0, 32'h0000_8001, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, LOAD_LH, STORE_DEF, 32'h0000_0500, 32'h0, 32'h0000_7FFF, 1'b1, 5'd11,
                 1'b1, 1'b0, 32'h0000_0500, 4'b1111, 32'h0, 32'h0000_7FFF, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, LOAD_LW, STORE_DEF, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 5'd12,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, LOAD_DEF, STORE_SH, 32'h0000_0201, 32'h5555_5555, 32'h0, 1'b0, 5'd0,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, LOAD_DEF, STORE_SB, 32'h0000_0001, 32'h0000_0042, 32'h0, 1'b0, 5'd0,
                 1'b1, 1'b1, 32'h0000_0000, 4'b0010, 32'h4242_4242, 32'h0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, LOAD_DEF, STORE_DEF, 32'h0000_0077, 32'h1111_1111, 32'h0, 1'b0, 5'd3,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0000_0077, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, LOAD_DEF, STORE_DEF, 32'h0000_0600, 32'h0, 32'h1122_3344, 1'b1, 5'd31,
                 1'b1, 1'b0, 32'h0000_0600, 4'b1111, 32'h0, 32'h1122_3344, 1'b1, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'd0;
    tick();
    tick();
    check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rst_be", {28'd0, bus.dmem_be}, 32'd0);
    check("rst_addr", bus.dmem_addr, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive_op(vecs[i].mem_write, vecs[i].wb_load, vecs[i].lt, vecs[i].st, vecs[i].addr,
               vecs[i].sdata, vecs[i].reg_file, vecs[i].rd);
      bus.dmem_ready = 1'b1;
      #1;
      check($sformatf("v%0d_accept_stall", i), {31'd0, mem_stall}, {31'd0, vecs[i].exp_mem});
      tick();
      in_valid = 1'b0;
      if (vecs[i].exp_mem) begin
        check($sformatf("v%0d_req", i), {31'd0, bus.dmem_req}, 32'd1);
        check($sformatf("v%0d_we", i), {31'd0, bus.dmem_we}, {31'd0, vecs[i].exp_we});
        check($sformatf("v%0d_daddr", i), bus.dmem_addr, vecs[i].exp_daddr);
        check($sformatf("v%0d_be", i), {28'd0, bus.dmem_be}, {28'd0, vecs[i].exp_be});
        if (vecs[i].exp_we) check($sformatf("v%0d_wdata", i), bus.dmem_wdata, vecs[i].exp_wdata);
        bus.dmem_rdata = vecs[i].rdata;
        #1;
        check($sformatf("v%0d_ready_stall", i), {31'd0, mem_stall}, 32'd0);
        tick();
      end
      check($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
      check($sformatf("v%0d_req_after", i), {31'd0, bus.dmem_req}, 32'd0);
      check($sformatf("v%0d_wb_rw", i), {31'd0, wb_reg_write}, {31'd0, vecs[i].exp_rw});
      check($sformatf("v%0d_wb_mis", i), {31'd0, wb_misalign}, {31'd0, vecs[i].exp_mis});
      check($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].rd});
      if (!vecs[i].exp_mis) check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_wb_data);
      bus.dmem_ready = 1'b0;
    end

    // LH with three wait cycles: stall spans accept plus the waits.
    tick();
    bus.dmem_ready = 1'b0;
    drive_op(1'b0, 1'b1, LOAD_LH, STORE_DEF, 32'h0000_0102, 32'h0, 1'b1, 5'd14);
    #1;
    begin
      int stall_cycles;
      stall_cycles = 0;
      if (mem_stall) stall_cycles++;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("wait%0d_req", k), {31'd0, bus.dmem_req}, 32'd1);
        check($sformatf("wait%0d_addr", k), bus.dmem_addr, 32'h0000_0100);
        check($sformatf("wait%0d_be", k), {28'd0, bus.dmem_be}, 32'h0000_000F);
        check($sformatf("wait%0d_wb_valid", k), {31'd0, wb_valid}, 32'd0);
        if (mem_stall) stall_cycles++;
        tick();
      end
      bus.dmem_ready = 1'b1;
      bus.dmem_rdata = 32'h8001_0000;
      #1;
      if (mem_stall) stall_cycles++;
      check("wait_stall_cycles", stall_cycles, 32'd4);
      tick();
      bus.dmem_ready = 1'b0;
      check("wait_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("wait_wb_data", wb_data, 32'hFFFF_8001);
    end

    // Reset while BUSY abandons the access.
    drive_op(1'b0, 1'b1, LOAD_LW, STORE_DEF, 32'h0000_0700, 32'h0, 1'b1, 5'd15);
    tick();
    in_valid = 1'b0;
    check("rb_req_busy", {31'd0, bus.dmem_req}, 32'd1);
    rst_n = 1'b0;
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'h9999_9999;
    tick();
    rst_n = 1'b1;
    bus.dmem_ready = 1'b0;
    #1;
    check("rb_req_dropped", {31'd0, bus.dmem_req}, 32'd0);
    check("rb_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rb_idle_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("rb_wb_valid2", {31'd0, wb_valid}, 32'd0);
    drive_op(1'b0, 1'b0, LOAD_DEF, STORE_DEF, 32'h0000_ABCD, 32'h0, 1'b1, 5'd2);
    tick();
    idle_inputs();
    check("rb_after_valid", {31'd0, wb_valid}, 32'd1);
    check("rb_after_data", wb_data, 32'h0000_ABCD);
    check("rb_after_req", {31'd0, bus.dmem_req}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
